// File: rtl/arcade_adec_gen.sv
// Z80 memory-map decoder for the arcade cores: chip selects, VRAM wait FSM, 74LS259-style latches,
// sound command register and VBLANK NMI. Define ARCADE_ADEC_WATCHDOG_EN to add the watchdog reset.
module arcade_adec_gen #(
   parameter logic [3:0]  ROM_TOP    = 4'h3,
   parameter logic [15:0] RAM_BASE   = 16'h6000,
   parameter int          NUM_RAM    = 3,
   parameter logic [15:0] VRAM_BASE  = 16'h7400,
   parameter logic [15:0] IN_BASE    = 16'h7C00,
   parameter int          NUM_IN     = 4,
   parameter logic [15:0] LATCH_BASE = 16'h7D00,
   parameter int          NUM_LATCH  = 2,
   parameter logic [15:0] SND_ADDR   = 16'h7C00,
   parameter int          NMI_BANK   = 1,
   parameter int          NMI_BIT    = 4,
   parameter int          TIMEOUT    = 64
`ifdef ARCADE_ADEC_WATCHDOG_EN
   ,
   parameter logic [15:0] WDOG_ADDR  = 16'h7D80
`endif
) (
   input  logic                     I_CLK24M,
   input  logic                     I_RESET_n,
   input  logic                     I_CLK_EN_P,
   input  logic [15:0]              I_AB,
   input  logic [7:0]               I_DB,
   input  logic                     I_MREQ_n,
   input  logic                     I_RFSH_n,
   input  logic                     I_RD_n,
   input  logic                     I_WR_n,
   input  logic                     I_VRAMBUSY_n,
   input  logic                     I_VBLK_n,
   output logic                     O_WAIT_n,
   output logic                     O_NMI_n,
   output logic                     O_ROM_CS_n,
   output logic [NUM_RAM-1:0]       O_RAM_CS_n,
   output logic                     O_VRAM_RD_n,
   output logic                     O_VRAM_WR_n,
   output logic [NUM_IN-1:0]        O_IN_OE_n,
   output logic [8*NUM_LATCH-1:0]   O_LATCH_Q,
   output logic [7:0]               O_SND_Q,
   output logic                     O_SND_STB,
`ifdef ARCADE_ADEC_WATCHDOG_EN
   output logic                     O_WDOG_RST_n,
`endif
   output logic                     O_WAIT_TO
);

   localparam int            CW       = $clog2(TIMEOUT) + 1;
   localparam logic [CW-1:0] CNT_LAST = CW'(TIMEOUT - 1);

   typedef enum logic [1:0] {
      ST_IDLE    = 2'd0,
      ST_BUSY    = 2'd1,
      ST_RELEASE = 2'd2
   } wait_state_t;

   wait_state_t                   state_q, state_d;
   logic [CW-1:0]                 cnt_q, cnt_d;
   logic                          wait_to_q, wait_to_d;
   logic                          wr_ok_q, wr_ok_d;
   logic [NUM_LATCH-1:0][7:0]     latch_q, latch_d;
   logic [7:0]                    snd_q, snd_d;
   logic                          snd_stb_q, snd_stb_d;
   logic                          nmi_q, nmi_d;
   logic                          wr_prev_q, wr_prev_d;
   logic                          vblk_s_q, vblk_s_d;
   logic                          vblk_p_q, vblk_p_d;

   logic mem_acc, rd, wr, wr_qual, wr_edge;
   logic vram_hit, vram_acc, vram_wr_ok, wait_n, nmi_en, blank_edge;

   always_comb begin
      mem_acc    = I_RFSH_n & ~I_MREQ_n;
      rd         = ~I_RD_n;
      wr         = ~I_WR_n;
      wr_qual    = mem_acc & wr;
      wr_edge    = wr_qual & ~wr_prev_q;
      vram_hit   = (I_AB[15:10] == VRAM_BASE[15:10]);
      vram_acc   = mem_acc & vram_hit & (rd | wr);
      blank_edge = vblk_p_q & ~vblk_s_q;
      nmi_en     = latch_q[NMI_BANK][NMI_BIT];
   end

   // Blank forces the CPU out of any wait at once, ahead of the state register.
   assign wait_n = (state_q != ST_BUSY) | ~I_VBLK_n;

   // Writes need a full tick of released wait, and are held off while VRAM is busy before the FSM reacts.
   assign vram_wr_ok = wr_ok_q & wait_n & ((state_q != ST_IDLE) | I_VRAMBUSY_n);

   always_comb begin
      O_ROM_CS_n  = ~(mem_acc & (I_AB[15:12] <= ROM_TOP));
      O_VRAM_RD_n = ~(mem_acc & vram_hit & rd);
      O_VRAM_WR_n = ~(mem_acc & vram_hit & wr & vram_wr_ok);
      O_RAM_CS_n  = '1;
      O_IN_OE_n   = '1;
      for (int n = 0; n < NUM_RAM; n++) begin
         if (mem_acc && (rd || wr) && (I_AB[15:10] == RAM_BASE[15:10] + 6'(n)))
            O_RAM_CS_n[n] = 1'b0;
      end
      for (int n = 0; n < NUM_IN; n++) begin
         if (mem_acc && rd && (I_AB[15:7] == IN_BASE[15:7] + 9'(n)))
            O_IN_OE_n[n] = 1'b0;
      end
   end

   always_comb begin
      state_d   = state_q;
      cnt_d     = cnt_q;
      wait_to_d = wait_to_q;
      wr_ok_d   = wr_ok_q;
      if (I_CLK_EN_P) begin
         wr_ok_d = wait_n;
         case (state_q)
            ST_IDLE: begin
               if (vram_acc && !I_VRAMBUSY_n) begin
                  state_d = ST_BUSY;
                  cnt_d   = '0;
               end
            end
            ST_BUSY: begin
               if (I_VRAMBUSY_n) begin
                  state_d = ST_RELEASE;
               end else if (cnt_q == CNT_LAST) begin
                  state_d   = ST_RELEASE;
                  wait_to_d = 1'b1;
               end else begin
                  cnt_d = cnt_q + CW'(1);
               end
            end
            // Held until the access ends so one access costs at most one wait.
            ST_RELEASE: begin
               if (I_MREQ_n) state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
         endcase
      end
      if (!I_VBLK_n) state_d = ST_IDLE;
   end

   always_comb begin
      latch_d   = latch_q;
      snd_d     = snd_q;
      snd_stb_d = 1'b0;
      nmi_d     = nmi_q;
      wr_prev_d = wr_qual;
      vblk_s_d  = I_VBLK_n;
      vblk_p_d  = vblk_s_q;
      for (int n = 0; n < NUM_LATCH; n++) begin
         if (wr_edge && (I_AB[15:7] == LATCH_BASE[15:7] + 9'(n)))
            latch_d[n][I_AB[2:0]] = I_DB[0];
      end
      if (wr_edge && (I_AB == SND_ADDR)) begin
         snd_d     = I_DB;
         snd_stb_d = 1'b1;
      end
      // Enable is the pre-write value, so a blank edge meeting the enabling write is ignored.
      if (!nmi_en)         nmi_d = 1'b1;
      else if (blank_edge) nmi_d = 1'b0;
   end

   always_ff @(posedge I_CLK24M or negedge I_RESET_n) begin
      if (!I_RESET_n) begin
         state_q   <= ST_IDLE;
         cnt_q     <= '0;
         wait_to_q <= 1'b0;
         wr_ok_q   <= 1'b1;
         latch_q   <= '0;
         snd_q     <= 8'h00;
         snd_stb_q <= 1'b0;
         nmi_q     <= 1'b1;
         wr_prev_q <= 1'b1;
         vblk_s_q  <= 1'b1;
         vblk_p_q  <= 1'b1;
      end else begin
         state_q   <= state_d;
         cnt_q     <= cnt_d;
         wait_to_q <= wait_to_d;
         wr_ok_q   <= wr_ok_d;
         latch_q   <= latch_d;
         snd_q     <= snd_d;
         snd_stb_q <= snd_stb_d;
         nmi_q     <= nmi_d;
         wr_prev_q <= wr_prev_d;
         vblk_s_q  <= vblk_s_d;
         vblk_p_q  <= vblk_p_d;
      end
   end

   assign O_WAIT_n  = wait_n;
   assign O_NMI_n   = nmi_q | ~nmi_en;
   assign O_LATCH_Q = latch_q;
   assign O_SND_Q   = snd_q;
   assign O_SND_STB = snd_stb_q;
   assign O_WAIT_TO = wait_to_q;

`ifdef ARCADE_ADEC_WATCHDOG_EN
   logic [19:0] wd_cnt_q, wd_cnt_d;
   logic [4:0]  wd_pulse_q, wd_pulse_d;

   always_comb begin
      wd_cnt_d   = wd_cnt_q;
      wd_pulse_d = (wd_pulse_q != 5'd0) ? wd_pulse_q - 5'd1 : 5'd0;
      if (wr_qual && (I_AB == WDOG_ADDR)) begin
         wd_cnt_d = '0;
      end else if (I_CLK_EN_P) begin
         if (&wd_cnt_q) begin
            wd_cnt_d   = '0;
            wd_pulse_d = 5'd16;
         end else begin
            wd_cnt_d = wd_cnt_q + 20'd1;
         end
      end
   end

   always_ff @(posedge I_CLK24M or negedge I_RESET_n) begin
      if (!I_RESET_n) begin
         wd_cnt_q   <= '0;
         wd_pulse_q <= 5'd0;
      end else begin
         wd_cnt_q   <= wd_cnt_d;
         wd_pulse_q <= wd_pulse_d;
      end
   end

   assign O_WDOG_RST_n = (wd_pulse_q == 5'd0);
`endif

endmodule
